bcd_countdown_timer: RTL and testbench
======================================

Name: bcd_countdown_timer

Overview:
Multi-digit BCD down-counter with load, start, pause-by-enable and optional auto-reload. It is the counting-down counterpart to the team's decade up-counter and uses the same clk/rst_n/enable/count/tc interface style. It serves as the programmable interval/timeout source for blocks that consume decade-counter ticks. A terminal-count flag and a one-cycle done pulse mark expiry.

Parameters:
DIGITS, 2, number of BCD digits; count width is 4*DIGITS.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst_n  input  1  asynchronous active-low reset.
load  input  1  load request; captures load_value.
load_value  input  4*DIGITS  BCD preset; digit i is bits [4i+3:4i].
start  input  1  IDLE->RUN request.
enable  input  1  tick qualifier; decrement only when high in RUN.
auto_reload  input  1  1 = periodic mode, 0 = one-shot.
count  output  4*DIGITS  current BCD value.
tc  output  1  combinational; high when count == 0.
done  output  1  registered one-cycle pulse when count reaches 0 in RUN.
busy  output  1  high while state == RUN.
load_err  output  1  registered one-cycle pulse on a rejected load.

Behaviour:
- Reset (async, rst_n=0): count=0, reload_reg=0, state=IDLE, done=0, load_err=0, busy=0, tc=1. Outputs change immediately, without waiting for a clock edge.
- States: IDLE, RUN. busy = (state==RUN).
- Priority on each edge: load > start > decrement.
- Load, valid case (load=1, every digit <=9), accepted in any state:
  - count <= load_value; reload_reg <= load_value; state <= IDLE.
  - A start on the same edge is ignored.
- Load, invalid case (load=1, any digit >9):
  - count, reload_reg and state are unchanged.
  - load_err=1 for one cycle. A start on the same edge is still ignored.
- Start, in IDLE with no load and count != 0: state <= RUN. There is no decrement on this edge.
  - Start with count == 0 is ignored.
  - Start while in RUN is ignored.
- Decrement, in RUN with enable=1 and count != 0: BCD subtract 1.
  - Digit 0 wraps to 9 and borrows into the next digit; a digit >0 decrements with no borrow.
  - Example: 0x10 -> 0x09; 0x100 -> 0x099 when DIGITS=3.
- In RUN with enable=0: count holds and state holds.
- Reaching zero (decrement with count==1 in the all-digit sense, i.e. next value 0):
  - count <= 0 and done <= 1 for exactly one cycle.
  - If auto_reload=0: state <= IDLE at the same edge.
  - If auto_reload=1: state stays RUN. The next enabled tick with count==0 loads count <= reload_reg, with no done pulse on that reload. Period = reload value + 1 enabled ticks.
- In RUN with count==0 and auto_reload=0: this cannot persist; state is IDLE.
- auto_reload is sampled at the edge where count reaches zero and at the reload edge.
- tc is purely combinational from count: high in IDLE after reset and at expiry.
- count never holds a non-BCD digit. The bench flags any digit >9 on any edge as an error.
- Reset mid-RUN: immediate return to the reset values, with no done pulse.

Test Plan:
1. Reset check: rst_n=0 for 2 cycles -> count=0x00, tc=1, busy=0, done=0, load_err=0.
2. One-shot countdown:
   - Stimulus: load 0x12, then start, enable=1, auto_reload=0.
   - Response: busy=1 after the start edge; count steps 0x11, 0x10, 0x09 ... 0x01, 0x00 over 12 edges.
   - On the final edge done=1 for one cycle, tc=1 and busy=0.
   - A further start with count=0 is ignored.
3. Pause: during run at 0x07, drop enable for 5 cycles -> count stays 0x07 and busy=1. Re-enabling resumes at 0x06.
4. Invalid and concurrent load:
   - load_value=0x1A -> load_err pulses once; count and reload_reg unchanged.
   - load=1 and start=1 on the same edge with a valid value -> count loaded, state IDLE.
   - load during RUN -> IDLE with the new value.
5. Auto-reload: load 0x03, auto_reload=1, start, enable=1 -> count 3,2,1,0,3,2,1,0,3. done pulses exactly at each transition to 0 (every 4 ticks); busy stays 1.
6. Async reset mid-run: assert rst_n low between clock edges at count 0x05 -> count=0x00, busy=0, tc=1 before the next edge. After release, the counter stays in IDLE until load/start.

Source files
------------

// File: rtl/bcd_countdown_timer_if.sv
// Control and status bundle for the BCD countdown timer.
// The master side issues load/start/enable/auto_reload requests; the
// slave side (the timer) returns count and status flags.
interface bcd_countdown_timer_if #(
  parameter int DIGITS = 2
);
  logic                  load;
  logic [4*DIGITS-1:0]   load_value;
  logic                  start;
  logic                  enable;
  logic                  auto_reload;
  logic [4*DIGITS-1:0]   count;
  logic                  tc;
  logic                  done;
  logic                  busy;
  logic                  load_err;

  modport master (
    output load, load_value, start, enable, auto_reload,
    input  count, tc, done, busy, load_err
  );

  modport slave (
    input  load, load_value, start, enable, auto_reload,
    output count, tc, done, busy, load_err
  );
endinterface

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD down-counter with load, start, pause-by-enable and
// optional auto-reload. Raises tc while the count is zero, pulses done for
// one cycle on expiry and pulses load_err for one cycle on a rejected load.
module bcd_countdown_timer #(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bcd_countdown_timer_if.slave  bus
);

  localparam int W = 4 * DIGITS;

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state;
  logic [W-1:0]   count_q;
  logic [W-1:0]   reload_q;
  logic           done_q;
  logic           load_err_q;

  // A preset is acceptable only if every nibble is a decimal digit.
  function automatic logic bcd_valid(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // Decimal subtract-one: a zero digit wraps to 9 and keeps the borrow
  // moving up; the first non-zero digit absorbs it.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Timer state: load beats start, start beats decrement. The count==1
  // test identifies the edge that lands on zero, which is where done fires
  // and where a one-shot run drops back to IDLE. A periodic run sits on
  // zero for one enabled tick and then reloads without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count_q    <= '0;
      reload_q   <= '0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
      if (bus.load) begin
        if (bcd_valid(bus.load_value)) begin
          count_q  <= bus.load_value;
          reload_q <= bus.load_value;
          state    <= IDLE;
        end else begin
          load_err_q <= 1'b1;
        end
      end else if (state == IDLE) begin
        if (bus.start && (count_q != '0)) state <= RUN;
      end else if (bus.enable) begin
        if (count_q == '0) begin
          if (bus.auto_reload) count_q <= reload_q;
          else                 state   <= IDLE;
        end else begin
          count_q <= bcd_dec(count_q);
          if (count_q == W'(1)) begin
            done_q <= 1'b1;
            if (!bus.auto_reload) state <= IDLE;
          end
        end
      end
    end
  end

  assign bus.count    = count_q;
  assign bus.tc       = (count_q == '0);
  assign bus.done     = done_q;
  assign bus.busy     = (state == RUN);
  assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: directed scenarios followed by random
// traffic, all checked every cycle against an integer-valued model.
module tb_bcd_countdown_timer;

  localparam int DIGITS = 2;
  localparam int W      = 4 * DIGITS;

  logic clk;
  logic rst_n;

  bcd_countdown_timer_if #(.DIGITS(DIGITS)) bus ();

  bcd_countdown_timer #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Model: the count is held as a plain decimal integer.
  int m_val;
  int m_rel;
  bit m_run;
  bit m_done;
  bit m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit valid_bcd(input logic [W-1:0] v);
    for (int d = 0; d < DIGITS; d++) if (v[4*d +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int bcd2int(input logic [W-1:0] v);
    int r;
    int p;
    r = 0;
    p = 1;
    for (int d = 0; d < DIGITS; d++) begin
      r += int'(v[4*d +: 4]) * p;
      p *= 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int x);
    logic [W-1:0] r;
    int           t;
    r = '0;
    t = x;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_val  = 0;
    m_rel  = 0;
    m_run  = 1'b0;
    m_done = 1'b0;
    m_err  = 1'b0;
  endtask

  task automatic model_step(input bit l, input logic [W-1:0] lv, input bit s,
                            input bit e, input bit ar);
    m_done = 1'b0;
    m_err  = 1'b0;
    if (l) begin
      if (valid_bcd(lv)) begin
        m_val = bcd2int(lv);
        m_rel = m_val;
        m_run = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end else if (!m_run) begin
      if (s && m_val != 0) m_run = 1'b1;
    end else if (e) begin
      if (m_val == 0) begin
        if (ar) m_val = m_rel;
        else    m_run = 1'b0;
      end else begin
        m_val = m_val - 1;
        if (m_val == 0) begin
          m_done = 1'b1;
          if (!ar) m_run = 1'b0;
        end
      end
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, and
  // return on the following falling edge.
  task automatic cycle(input bit l, input logic [W-1:0] lv, input bit s,
                       input bit e, input bit ar);
    bus.load        = l;
    bus.load_value  = lv;
    bus.start       = s;
    bus.enable      = e;
    bus.auto_reload = ar;
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step(l, lv, s, e, ar);
    @(negedge clk);
  endtask

  // Pull reset between edges and confirm the outputs clear before any edge.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_async_count", 32'(bus.count), 32'h0);
    chk("rst_async_busy",  32'(bus.busy),  32'h0);
    chk("rst_async_tc",    32'(bus.tc),    32'h1);
    chk("rst_async_done",  32'(bus.done),  32'h0);
    @(negedge clk);
    cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
  endtask

  bit check_en;

  // Every falling edge: DUT outputs against the model, plus a BCD-digit check.
  always @(negedge clk) begin
    if (check_en) begin
      chk("count",    32'(bus.count),    32'(int2bcd(m_val)));
      chk("tc",       32'(bus.tc),       32'(m_val == 0));
      chk("busy",     32'(bus.busy),     32'(m_run));
      chk("done",     32'(bus.done),     32'(m_done));
      chk("load_err", 32'(bus.load_err), 32'(m_err));
      for (int d = 0; d < DIGITS; d++)
        chk("digit_bcd", 32'(bus.count[4*d +: 4] > 4'd9), 32'h0);
    end
  end

  initial begin
    logic [W-1:0] lv;
    logic [W-1:0] ar_cnt [9];
    bit           ar_dn  [9];
    bit           ar;

    n_vec    = 0;
    n_err    = 0;
    check_en = 1'b0;
    model_reset();
    rst_n           = 1'b0;
    bus.load        = 1'b0;
    bus.load_value  = '0;
    bus.start       = 1'b0;
    bus.enable      = 1'b0;
    bus.auto_reload = 1'b0;
    @(negedge clk);
    check_en = 1'b1;

    // Reset held for two cycles.
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("reset_count", 32'(bus.count), 32'h0);
    chk("reset_tc",    32'(bus.tc),    32'h1);
    chk("reset_busy",  32'(bus.busy),  32'h0);
    rst_n = 1'b1;

    // One-shot countdown from 12.
    cycle(1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("os_busy_after_start", 32'(bus.busy),  32'h1);
    chk("os_count_after_start", 32'(bus.count), 32'h12);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("os_borrow_10_to_09", 32'(bus.count), 32'h09);
    for (int i = 0; i < 9; i++) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("os_final_count", 32'(bus.count), 32'h00);
    chk("os_final_done",  32'(bus.done),  32'h1);
    chk("os_final_tc",    32'(bus.tc),    32'h1);
    chk("os_final_busy",  32'(bus.busy),  32'h0);
    cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
    chk("os_start_at_zero", 32'(bus.busy), 32'h0);
    chk("os_done_one_cycle", 32'(bus.done), 32'h0);

    // Pause by dropping enable.
    cycle(1'b1, 8'h09, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("pause_count", 32'(bus.count), 32'h07);
    chk("pause_busy",  32'(bus.busy),  32'h1);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("resume_count", 32'(bus.count), 32'h06);

    // Invalid load, load+start together, load during RUN.
    cycle(1'b1, 8'h1A, 1'b0, 1'b1, 1'b0);
    chk("bad_load_err",   32'(bus.load_err), 32'h1);
    chk("bad_load_count", 32'(bus.count),    32'h06);
    chk("bad_load_busy",  32'(bus.busy),     32'h1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("bad_load_pulse", 32'(bus.load_err), 32'h0);
    cycle(1'b1, 8'h25, 1'b1, 1'b1, 1'b0);
    chk("load_start_count", 32'(bus.count), 32'h25);
    chk("load_start_busy",  32'(bus.busy),  32'h0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 8'h40, 1'b0, 1'b1, 1'b0);
    chk("load_in_run_count", 32'(bus.count), 32'h40);
    chk("load_in_run_busy",  32'(bus.busy),  32'h0);

    // Auto-reload with period 4.
    ar_cnt = '{8'h02, 8'h01, 8'h00, 8'h03, 8'h02, 8'h01, 8'h00, 8'h03, 8'h02};
    ar_dn  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    cycle(1'b1, 8'h03, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
    chk("ar_start_count", 32'(bus.count), 32'h03);
    for (int i = 0; i < 9; i++) begin
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
      chk("ar_count", 32'(bus.count), 32'(ar_cnt[i]));
      chk("ar_done",  32'(bus.done),  32'(ar_dn[i]));
      chk("ar_busy",  32'(bus.busy),  32'h1);
    end

    // Async reset mid-run at 05.
    cycle(1'b1, 8'h09, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("pre_reset_count", 32'(bus.count), 32'h05);
    async_reset();
    cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
    chk("post_reset_busy",  32'(bus.busy),  32'h0);
    chk("post_reset_count", 32'(bus.count), 32'h00);

    // Random traffic.
    ar = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        async_reset();
      end else begin
        if ($urandom_range(0, 63) == 0) ar = ~ar;
        if ($urandom_range(0, 3) == 0) begin
          lv = W'($urandom);
        end else begin
          for (int d = 0; d < DIGITS; d++) lv[4*d +: 4] = 4'($urandom_range(0, 9));
          if ($urandom_range(0, 1) == 0) lv[W-1:4] = '0;
        end
        cycle(($urandom_range(0, 19) == 0), lv, ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 3) != 0), ar);
      end
    end

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
